// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite command master: turns single-beat local commands into AXI4-Lite
// read/write transactions and returns the result on a valid/ready response port.
// One transaction in flight; every AXI output and rsp_* field is registered.
module axi4_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // Local command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // Local response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0] M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [STRB_WIDTH-1:0] M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  // Counter must be able to hold TIMEOUT_CYCLES; it saturates there so a
  // handshake that beats the timeout still leaves the next phase guarded.
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdAddr,
    StRdData,
    StResp
  } state_t;

  state_t          state;
  logic [CntW-1:0] tmo_cnt;
  logic            aw_done;
  logic            w_done;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic any_hs, busy, tmo_hit;

  assign aw_hs   = M_AWVALID & M_AWREADY;
  assign w_hs    = M_WVALID & M_WREADY;
  assign b_hs    = M_BREADY & M_BVALID;
  assign ar_hs   = M_ARVALID & M_ARREADY;
  assign r_hs    = M_RREADY & M_RVALID;
  assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign busy    = (state == StWrReq) || (state == StWrResp) ||
                   (state == StRdAddr) || (state == StRdData);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TmoMax);

  // Ready to take a command only when nothing is in flight.
  assign cmd_ready = (state == StIdle);

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= StIdle;
      tmo_cnt     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      M_AWADDR    <= '0;
      M_AWVALID   <= 1'b0;
      M_WDATA     <= '0;
      M_WSTRB     <= '0;
      M_WVALID    <= 1'b0;
      M_BREADY    <= 1'b0;
      M_ARADDR    <= '0;
      M_ARVALID   <= 1'b0;
      M_RREADY    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      if (busy && (tmo_cnt != TmoMax)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (busy && tmo_hit && !any_hs) begin
        // Abort: release the bus and report a timeout as SLVERR.
        M_AWADDR    <= '0;
        M_AWVALID   <= 1'b0;
        M_WDATA     <= '0;
        M_WSTRB     <= '0;
        M_WVALID    <= 1'b0;
        M_BREADY    <= 1'b0;
        M_ARADDR    <= '0;
        M_ARVALID   <= 1'b0;
        M_RREADY    <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_write   <= (state == StWrReq) || (state == StWrResp);
        rsp_rdata   <= '0;
        rsp_resp    <= 2'b10;
        rsp_timeout <= 1'b1;
        state       <= StResp;
      end else begin
        case (state)
          StIdle: begin
            if (cmd_valid) begin
              tmo_cnt <= '0;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              if (cmd_write) begin
                M_AWADDR  <= cmd_addr;
                M_AWVALID <= 1'b1;
                M_WDATA   <= cmd_wdata;
                M_WSTRB   <= cmd_wstrb;
                M_WVALID  <= 1'b1;
                state     <= StWrReq;
              end else begin
                M_ARADDR  <= cmd_addr;
                M_ARVALID <= 1'b1;
                state     <= StRdAddr;
              end
            end
          end

          StWrReq: begin
            // AW and W complete independently; sticky flags remember which.
            if (aw_hs) begin
              M_AWADDR  <= '0;
              M_AWVALID <= 1'b0;
              aw_done   <= 1'b1;
            end
            if (w_hs) begin
              M_WDATA  <= '0;
              M_WSTRB  <= '0;
              M_WVALID <= 1'b0;
              w_done   <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
              M_BREADY <= 1'b1;
              state    <= StWrResp;
            end
          end

          StWrResp: begin
            if (b_hs) begin
              M_BREADY    <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_write   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_resp    <= M_BRESP;
              rsp_timeout <= 1'b0;
              state       <= StResp;
            end
          end

          StRdAddr: begin
            if (ar_hs) begin
              M_ARADDR  <= '0;
              M_ARVALID <= 1'b0;
              M_RREADY  <= 1'b1;
              state     <= StRdData;
            end
          end

          StRdData: begin
            if (r_hs) begin
              M_RREADY    <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_write   <= 1'b0;
              rsp_rdata   <= M_RDATA;
              rsp_resp    <= M_RRESP;
              rsp_timeout <= 1'b0;
              state       <= StResp;
            end
          end

          StResp: begin
            if (rsp_ready) begin
              rsp_valid   <= 1'b0;
              rsp_write   <= 1'b0;
              rsp_rdata   <= '0;
              rsp_resp    <= 2'b00;
              rsp_timeout <= 1'b0;
              state       <= StIdle;
            end
          end

          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master: a 32-bit instance with an 8-cycle
// timeout and a 64-bit instance, both driven by one linear stimulus sequence.
module tb_axi4_lite_cmd_master;

  logic ACLK = 1'b0;
  logic ARESETN;

  always #5 ACLK = ~ACLK;

  // 32-bit instance signals
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  // 64-bit instance signals
  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [31:0] b_cmd_addr;
  logic [63:0] b_cmd_wdata;
  logic [7:0]  b_cmd_wstrb;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_write, b_rsp_timeout;
  logic [63:0] b_rsp_rdata;
  logic [1:0]  b_rsp_resp;
  logic [31:0] b_awaddr, b_araddr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_wstrb;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready;
  logic [1:0]  b_bresp, b_rresp;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  axi4_lite_cmd_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AWADDR   (awaddr),
    .M_AWVALID  (awvalid),
    .M_AWREADY  (awready),
    .M_WDATA    (wdata),
    .M_WSTRB    (wstrb),
    .M_WVALID   (wvalid),
    .M_WREADY   (wready),
    .M_BRESP    (bresp),
    .M_BVALID   (bvalid),
    .M_BREADY   (bready),
    .M_ARADDR   (araddr),
    .M_ARVALID  (arvalid),
    .M_ARREADY  (arready),
    .M_RDATA    (rdata),
    .M_RRESP    (rresp),
    .M_RVALID   (rvalid),
    .M_RREADY   (rready)
  );

  axi4_lite_cmd_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (64),
    .TIMEOUT_CYCLES(256)
  ) dut64 (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cmd_valid  (b_cmd_valid),
    .cmd_ready  (b_cmd_ready),
    .cmd_write  (b_cmd_write),
    .cmd_addr   (b_cmd_addr),
    .cmd_wdata  (b_cmd_wdata),
    .cmd_wstrb  (b_cmd_wstrb),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (b_rsp_ready),
    .rsp_write  (b_rsp_write),
    .rsp_rdata  (b_rsp_rdata),
    .rsp_resp   (b_rsp_resp),
    .rsp_timeout(b_rsp_timeout),
    .M_AWADDR   (b_awaddr),
    .M_AWVALID  (b_awvalid),
    .M_AWREADY  (b_awready),
    .M_WDATA    (b_wdata),
    .M_WSTRB    (b_wstrb),
    .M_WVALID   (b_wvalid),
    .M_WREADY   (b_wready),
    .M_BRESP    (b_bresp),
    .M_BVALID   (b_bvalid),
    .M_BREADY   (b_bready),
    .M_ARADDR   (b_araddr),
    .M_ARVALID  (b_arvalid),
    .M_ARREADY  (b_arready),
    .M_RDATA    (b_rdata),
    .M_RRESP    (b_rresp),
    .M_RVALID   (b_rvalid),
    .M_RREADY   (b_rready)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ARESETN     = 1'b0;
    cmd_valid   = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready   = 1'b0;
    awready     = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready     = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
    b_cmd_wstrb = '0;   b_rsp_ready = 1'b0;
    b_awready   = 1'b0; b_wready = 1'b0; b_bvalid = 1'b0; b_bresp = 2'b00;
    b_arready   = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_rresp = 2'b00;

    // ---------------- reset state
    step(); step();
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, 0);
    chk("rst_bus", {awaddr, wdata, wstrb, araddr}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst64_valids", {b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready, b_rsp_valid}, 0);
    chk("rst64_bus", {b_awaddr, b_araddr, b_wstrb}, 0);
    chk("rst64_cmd_ready", b_cmd_ready, 1);
    ARESETN = 1'b1;
    step();

    // ---------------- write, slave always ready
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010;
    cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'b0011;
    step();  // accept
    cmd_valid = 1'b0;
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid", wvalid, 1);
    chk("w1_awaddr", awaddr, 32'h0000_0010);
    chk("w1_wdata", wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb", wstrb, 4'b0011);
    chk("w1_cmd_ready_busy", cmd_ready, 0);
    chk("w1_bready_early", bready, 0);
    step();  // AW and W handshake together
    chk("w1_valids_drop", {awvalid, wvalid}, 0);
    chk("w1_bready", bready, 1);
    chk("w1_addr_cleared", awaddr, 0);
    chk("w1_rsp_not_yet", rsp_valid, 0);
    step();  // B handshake
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_resp", rsp_resp, 2'b00);
    chk("w1_rsp_write", rsp_write, 1);
    chk("w1_rsp_rdata", rsp_rdata, 0);
    chk("w1_bready_drop", bready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w1_back_idle", {cmd_ready, rsp_valid}, 2'b10);

    // ---------------- write, W accepted two cycles before AW
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020;
    cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'b1111;
    step();  // accept
    cmd_valid = 1'b0;
    chk("w2_both_valid", {awvalid, wvalid}, 2'b11);
    step();  // W handshake only
    wready = 1'b0;
    chk("w2_wvalid_drop", wvalid, 0);
    chk("w2_awvalid_hold", awvalid, 1);
    chk("w2_awaddr_hold", awaddr, 32'h0000_0020);
    chk("w2_no_bready", bready, 0);
    step();
    chk("w2_awvalid_hold2", awvalid, 1);
    chk("w2_awaddr_hold2", awaddr, 32'h0000_0020);
    awready = 1'b1;
    step();  // AW handshake
    awready = 1'b0;
    chk("w2_aw_drop", awvalid, 0);
    chk("w2_bready", bready, 1);
    bvalid = 1'b1; bresp = 2'b00;
    step();  // single B handshake
    bvalid = 1'b0;
    chk("w2_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, 5'b11000);
    chk("w2_bready_drop", bready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ---------------- read, ARREADY delayed 3 cycles, SLVERR data
    arready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
    step();  // accept
    cmd_valid = 1'b0;
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr", araddr, 32'h0000_0040);
    chk("r1_no_write", {awvalid, wvalid}, 0);
    step(); step();
    chk("r1_arvalid_hold", {arvalid, rready}, 2'b10);
    chk("r1_araddr_hold", araddr, 32'h0000_0040);
    arready = 1'b1;
    step();  // AR handshake
    arready = 1'b0;
    chk("r1_ar_drop", arvalid, 0);
    chk("r1_rready", rready, 1);
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
    step();  // R handshake
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("r1_rsp_resp", rsp_resp, 2'b10);
    chk("r1_rsp_flags", {rsp_write, rsp_timeout, rready}, 0);

    // ---------------- response back-pressure with a command waiting
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0044;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("bp_rsp_resp", rsp_resp, 2'b10);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_arvalid", arvalid, 0);
    end
    rsp_ready = 1'b1;
    step();  // response consumed
    rsp_ready = 1'b0;
    chk("bp_idle", {cmd_ready, rsp_valid}, 2'b10);
    step();  // waiting command accepted
    cmd_valid = 1'b0;
    chk("bp_next_arvalid", arvalid, 1);
    chk("bp_next_araddr", araddr, 32'h0000_0044);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_CAFE; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    chk("bp_next_rdata", rsp_rdata, 32'h0000_CAFE);
    chk("bp_next_resp", {rsp_valid, rsp_resp}, 3'b100);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ---------------- timeout, ARREADY never asserted (TIMEOUT_CYCLES = 8)
    arready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080;
    step();  // accept, counter cleared
    cmd_valid = 1'b0;
    chk("to_arvalid_start", arvalid, 1);
    for (int i = 1; i <= 8; i++) begin
      step();  // counter reaches i
      chk("to_arvalid_wait", {arvalid, rsp_valid}, 2'b10);
    end
    step();  // counter at 8: abort
    chk("to_arvalid_drop", arvalid, 0);
    chk("to_araddr_clear", araddr, 0);
    chk("to_rready", rready, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_resp", rsp_resp, 2'b10);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_rsp_write", rsp_write, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_back_idle", {cmd_ready, rsp_valid, rsp_timeout}, 3'b100);

    // ---------------- reset while in WR_RESP with BVALID pending
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0030;
    cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'b1000;
    step();  // accept
    cmd_valid = 1'b0;
    step();  // AW/W handshake
    awready = 1'b0; wready = 1'b0;
    chk("rr_bready", bready, 1);
    bvalid = 1'b1; bresp = 2'b01;
    ARESETN = 1'b0;
    step();
    chk("rr_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rr_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, 0);
    chk("rr_bus", {awaddr, wdata, wstrb, araddr}, 0);
    chk("rr_cmd_ready", cmd_ready, 1);
    ARESETN = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    step();
    chk("rr_no_rsp", {rsp_valid, bready}, 0);
    arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100;
    step();  // accept
    cmd_valid = 1'b0;
    chk("rr_rd_araddr", araddr, 32'h0000_0100);
    step();  // AR handshake
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b00;
    step();  // R handshake
    rvalid = 1'b0;
    chk("rr_rd_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, 5'b10000);
    chk("rr_rd_rdata", rsp_rdata, 32'h0BAD_F00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ---------------- 64-bit write, slave always ready
    b_awready = 1'b1; b_wready = 1'b1; b_bvalid = 1'b1; b_bresp = 2'b00;
    b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 32'h0000_0010;
    b_cmd_wdata = 64'hDEAD_BEEF_0123_4567; b_cmd_wstrb = 8'b0000_1111;
    step();  // accept
    b_cmd_valid = 1'b0;
    chk("w64_valids", {b_awvalid, b_wvalid}, 2'b11);
    chk("w64_awaddr", b_awaddr, 32'h0000_0010);
    chk("w64_wdata", b_wdata, 64'hDEAD_BEEF_0123_4567);
    chk("w64_wstrb", b_wstrb, 8'b0000_1111);
    step();
    chk("w64_bready", {b_awvalid, b_wvalid, b_bready}, 3'b001);
    step();
    chk("w64_rsp", {b_rsp_valid, b_rsp_write, b_rsp_timeout, b_rsp_resp}, 5'b11000);
    chk("w64_rdata_zero", b_rsp_rdata, 0);
    b_bvalid = 1'b0; b_awready = 1'b0; b_wready = 1'b0;
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;

    // ---------------- 64-bit read, ARREADY delayed 3 cycles
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 32'h0000_0040;
    step();  // accept
    b_cmd_valid = 1'b0;
    chk("r64_araddr", b_araddr, 32'h0000_0040);
    step(); step();
    chk("r64_arvalid_hold", {b_arvalid, b_rready}, 2'b10);
    b_arready = 1'b1;
    step();
    b_arready = 1'b0;
    chk("r64_rready", {b_arvalid, b_rready}, 2'b01);
    b_rvalid = 1'b1; b_rdata = 64'h1234_5678_9ABC_DEF0; b_rresp = 2'b10;
    step();
    b_rvalid = 1'b0; b_rdata = '0; b_rresp = 2'b00;
    chk("r64_rsp_rdata", b_rsp_rdata, 64'h1234_5678_9ABC_DEF0);
    chk("r64_rsp", {b_rsp_valid, b_rsp_write, b_rsp_timeout, b_rsp_resp}, 5'b10010);
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    chk("r64_back_idle", {b_cmd_ready, b_rsp_valid}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

Parametrised AXI4-Lite master that turns single-beat commands from a local valid/ready command port into AXI4-Lite read or write transactions and returns the result on a valid/ready response port. It supersedes the fixed 32-bit, level-start master: it adds configurable address and data widths, caller-supplied write strobes, independent AW/W handshake completion, registered and stable AXI outputs, response back-pressure, and a per-transaction timeout. It sits between a local controller (sequencer, CPU bridge, testbench driver) and any AXI4-Lite slave or interconnect.

## Interface
- ADDR_WIDTH, 32, address width of the command and AR/AW channels
- DATA_WIDTH, 32, data width; legal values 32 or 64
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; derived, not overridden
- TIMEOUT_CYCLES, 256, maximum cycles a transaction may wait for slave handshakes; 0 disables the timeout
- ACLK  in  1  clock
- ARESETN  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transaction address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- cmd_wstrb  in  STRB_WIDTH  write byte strobes; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  out  2  AXI RRESP or BRESP; 2'b10 on timeout
- rsp_timeout  out  1  transaction aborted by timeout
- M_AWADDR, M_AWVALID, M_AWREADY; M_WDATA, M_WSTRB, M_WVALID, M_WREADY; M_BRESP, M_BVALID, M_BREADY; M_ARADDR, M_ARVALID, M_ARREADY; M_RDATA, M_RRESP, M_RVALID, M_RREADY: standard AXI4-Lite master ports, widths ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH or 2 as applicable

## Operation
- States:
  - IDLE
  - WR_REQ: AW and W outstanding
  - WR_RESP
  - RD_ADDR
  - RD_DATA
  - RESP: holding the result
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr, wdata and wstrb.
  - Go to WR_REQ if cmd_write, otherwise RD_ADDR.
- WR_REQ:
  - M_AWVALID and M_WVALID are asserted together.
  - Each is dropped independently the cycle after its own handshake; the done state is kept in sticky aw_done/w_done flags.
  - When both are done, go to WR_RESP. Both may complete in the same cycle, in either order, or with W before AW.
- WR_RESP:
  - M_BREADY=1.
  - On M_BVALID, capture BRESP and go to RESP.
- RD_ADDR:
  - M_ARVALID=1.
  - On M_ARREADY, go to RD_DATA.
- RD_DATA:
  - M_RREADY=1.
  - On M_RVALID, capture RDATA and RRESP and go to RESP.
- RESP:
  - rsp_valid=1, with rsp_* fields stable.
  - On rsp_ready, go to IDLE.
  - No new command is accepted until the response is consumed (one transaction in flight).
- Timeout:
  - A counter clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_ADDR or RD_DATA.
  - When the counter equals TIMEOUT_CYCLES (nonzero), all AXI valids/readies drop next cycle and the FSM goes to RESP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
  - A handshake completing in the same cycle as the timeout wins: the FSM progresses normally.
- Address and data outputs:
  - M_AWADDR, M_ARADDR, M_WDATA and M_WSTRB are driven from the captured registers and held stable while the associated valid is high.
  - They are 0 when not valid.
- RRESP/BRESP values are passed through unmodified; SLVERR and DECERR are not retried.

## Timing
- Reset (ARESETN=0 at a rising edge), all outputs 0:
  - state=IDLE; cmd_ready reads 1 once state is IDLE.
  - All M_*VALID/READY = 0; M_*ADDR/DATA/STRB = 0.
  - rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout = 0; counter = 0.
- Reset mid-transaction abandons it immediately; no response is produced.
- All AXI outputs and rsp_* are registered (no combinational path from any input to any output); cmd_ready is a decode of state.
- Command accepted at edge N: M_AWVALID/M_WVALID or M_ARVALID are high from N+1.
- Handshake at edge K:
  - The corresponding valid is low from K+1.
  - The next phase's ready is high from K+1.
- Response:
  - B or R handshake at edge K: rsp_valid high from K+1.
  - rsp_ready at edge J: cmd_ready high from J+1.
- Minimum latency, slave always ready:
  - Write: command to rsp_valid = 3 cycles.
  - Read: command to rsp_valid = 3 cycles.
  - Back-to-back throughput: one transaction per 4 cycles.
- M_BREADY and M_RREADY are never asserted before their address/data phase completes.

## Test plan
- Write, slave always ready, addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'b0011:
  - AW/W valid 1 cycle after accept with exact values.
  - rsp_valid 3 cycles after accept, rsp_resp=0, rsp_write=1.
- Write with WREADY 2 cycles before AWREADY:
  - WVALID drops after its handshake while AWVALID stays high and AWADDR is stable.
  - Single B handshake; OKAY response.
- Read addr 0x0000_0040, ARREADY delayed 3 cycles, RDATA 0x1234_5678 with RRESP 2'b10:
  - rsp_rdata=0x1234_5678, rsp_resp=2'b10, rsp_timeout=0.
- TIMEOUT_CYCLES=8, slave never asserts ARREADY:
  - M_ARVALID drops after 8 cycles.
  - rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
- rsp_ready held low 5 cycles, cmd_valid high throughout:
  - rsp_* stable and cmd_ready=0 for all 5 cycles.
  - Next command accepted the cycle after rsp_ready.
- ARESETN low in WR_RESP with BVALID pending:
  - All outputs 0 next cycle; no rsp_valid.
  - A following read completes normally; DATA_WIDTH=64 variant repeats scenarios 1 and 3 with 8-bit strobes.
